// File: rtl/bin_row_tap_buffer_if.sv
// Handshake and tap bundle between the raster pixel source, the 3-row tap buffer
// and the downstream three-input OR dilation stage.
interface bin_row_tap_buffer_if #(
  parameter int COL_W = 5,
  parameter int ROW_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic             tap_top;
  logic             tap_mid;
  logic             tap_bot;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             frame_done;

  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, tap_top, tap_mid, tap_bot, out_col, out_row, frame_done
  );

  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, tap_top, tap_mid, tap_bot, out_col, out_row, frame_done
  );
endinterface

// File: rtl/bin_row_tap_buffer.sv
// Streaming 3-row line buffer turning a binary raster stream into vertical (top,mid,bot) triplets.
// Optional macro BIN_TAP_BORDER_REPLICATE_EN: border rows replicate the middle tap instead of zero padding.
module bin_row_tap_buffer #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int COL_W      = 5,
  parameter int ROW_W      = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  bin_row_tap_buffer_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] FIRST_K  = ROW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t               r_state;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [IMG_WIDTH-1:0] r_prev;
  logic [IMG_WIDTH-1:0] r_cur;
  logic                 r_fl_all;

  logic                 r_vld_p1;
  logic                 r_top_p1;
  logic                 r_mid_p1;
  logic                 r_bot_p1;
  logic [COL_W-1:0]     r_col_p1;
  logic [ROW_W-1:0]     r_row_p1;
  logic                 r_done_p1;

  logic                 w_in_ready;
  logic                 w_out_free;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_top_stream;
  logic                 w_bot_flush;

  assign w_out_free = !r_vld_p1 || bus.out_ready;
  assign w_out_xfer = r_vld_p1 && bus.out_ready;
  assign w_in_xfer  = bus.in_valid && w_in_ready;

  always_comb begin
    w_in_ready = 1'b0;
    unique case (r_state)
      S_IDLE:   w_in_ready = 1'b1;
      S_FILL:   w_in_ready = 1'b1;
      S_STREAM: w_in_ready = w_out_free;
      S_FLUSH:  w_in_ready = 1'b0;
      default:  w_in_ready = 1'b0;
    endcase
  end

  // Row 0 has no row above it; row IMG_HEIGHT-1 has no row below it.
`ifdef BIN_TAP_BORDER_REPLICATE_EN
  assign w_top_stream = (r_row == FIRST_K) ? r_cur[r_col] : r_prev[r_col];
  assign w_bot_flush  = r_cur[r_col];
`else
  assign w_top_stream = (r_row == FIRST_K) ? 1'b0 : r_prev[r_col];
  assign w_bot_flush  = 1'b0;
`endif

  // p0 -> p1: accepted pixel (or flush column) loads the single output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_prev    <= '0;
      r_cur     <= '0;
      r_fl_all  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_top_p1  <= 1'b0;
      r_mid_p1  <= 1'b0;
      r_bot_p1  <= 1'b0;
      r_col_p1  <= '0;
      r_row_p1  <= '0;
      r_done_p1 <= 1'b0;
    end else begin
      r_done_p1 <= 1'b0;
      if (w_out_xfer) r_vld_p1 <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_in_xfer && bus.in_sof) begin
            r_cur[0] <= bus.in_pix;
            r_col    <= COL_W'(1);
            r_row    <= '0;
            r_state  <= S_FILL;
          end
        end

        S_FILL, S_STREAM: begin
          if (w_in_xfer) begin
            if (bus.in_sof) begin
              // Restart: the new pixel is row 0 col 0 and any pending triplet is dropped
              r_cur[0] <= bus.in_pix;
              r_col    <= COL_W'(1);
              r_row    <= '0;
              r_vld_p1 <= 1'b0;
              r_state  <= S_FILL;
            end else if (r_state == S_FILL) begin
              r_cur[r_col] <= bus.in_pix;
              if (r_col == LAST_COL) begin
                r_col   <= '0;
                r_row   <= FIRST_K;
                r_state <= S_STREAM;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end else begin
              r_vld_p1      <= 1'b1;
              r_top_p1      <= w_top_stream;
              r_mid_p1      <= r_cur[r_col];
              r_bot_p1      <= bus.in_pix;
              r_col_p1      <= r_col;
              r_row_p1      <= r_row - FIRST_K;
              r_prev[r_col] <= r_cur[r_col];
              r_cur[r_col]  <= bus.in_pix;
              if (r_col == LAST_COL) begin
                r_col <= '0;
                if (r_row == LAST_ROW) begin
                  r_fl_all <= 1'b0;
                  r_state  <= S_FLUSH;
                end else begin
                  r_row <= r_row + FIRST_K;
                end
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
        end

        S_FLUSH: begin
          if (!r_fl_all) begin
            if (w_out_free) begin
              r_vld_p1 <= 1'b1;
              r_top_p1 <= r_prev[r_col];
              r_mid_p1 <= r_cur[r_col];
              r_bot_p1 <= w_bot_flush;
              r_col_p1 <= r_col;
              r_row_p1 <= LAST_ROW;
              if (r_col == LAST_COL) begin
                r_col    <= '0;
                r_fl_all <= 1'b1;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end else if (w_out_xfer) begin
            r_done_p1 <= 1'b1;
            r_fl_all  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_vld_p1;
  assign bus.tap_top    = r_top_p1;
  assign bus.tap_mid    = r_mid_p1;
  assign bus.tap_bot    = r_bot_p1;
  assign bus.out_col    = r_col_p1;
  assign bus.out_row    = r_row_p1;
  assign bus.frame_done = r_done_p1;

endmodule

// File: tb/tb_bin_row_tap_buffer.sv
// Scoreboard bench for bin_row_tap_buffer on a 4x3 image: stimulus pushes expected triplets,
// a negedge monitor pops and compares every transferred triplet and every frame_done pulse.
module tb_bin_row_tap_buffer;
  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic       t;
    logic       m;
    logic       b;
    logic [1:0] row;
    logic [1:0] col;
  } trip_t;

  logic clk;
  logic rst_n;
  bin_row_tap_buffer_if #(.COL_W(2), .ROW_W(2)) bus ();

  bin_row_tap_buffer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (2),
    .ROW_W     (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  trip_t      q[$];
  trip_t      mon_e;
  trip_t      mon_g;
  logic [W-1:0] img [H];   // written left-to-right: MSB is column 0
  int         n_tests;
  int         n_fail;
  int         n_out;
  int         n_done;
  int         exp_done;
  logic       stall_arm;
  logic       stall_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      n_tests++;
      mon_g = '{t: bus.tap_top, m: bus.tap_mid, b: bus.tap_bot, row: bus.out_row, col: bus.out_col};
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_triplet got tmb=%b%b%b r%0d c%0d required none",
                 mon_g.t, mon_g.m, mon_g.b, mon_g.row, mon_g.col);
      end else begin
        mon_e = q.pop_front();
        if (mon_g != mon_e) begin
          n_fail++;
          $display("FAIL triplet got tmb=%b%b%b r%0d c%0d required tmb=%b%b%b r%0d c%0d",
                   mon_g.t, mon_g.m, mon_g.b, mon_g.row, mon_g.col,
                   mon_e.t, mon_e.m, mon_e.b, mon_e.row, mon_e.col);
        end
      end
    end
    if (rst_n && bus.frame_done) begin
      n_done++;
      n_tests++;
      if (!(bus.out_row == 2'd2 && bus.out_col == 2'd3 && !bus.out_valid)) begin
        n_fail++;
        $display("FAIL frame_done_coord got r%0d c%0d v%0b required r2 c3 v0",
                 bus.out_row, bus.out_col, bus.out_valid);
      end
    end
  end

  function automatic logic px(input int r, input int c);
    logic [W-1:0] row_bits;
    row_bits = img[r];
    return row_bits[W-1-c];
  endfunction

  task automatic push_model(input int r, input int c);
    trip_t e;
    e.m = px(r, c);
`ifdef BIN_TAP_BORDER_REPLICATE_EN
    if (r == 0) e.t = e.m; else e.t = px(r-1, c);
    if (r == H-1) e.b = e.m; else e.b = px(r+1, c);
`else
    if (r == 0) e.t = 1'b0; else e.t = px(r-1, c);
    if (r == H-1) e.b = 1'b0; else e.b = px(r+1, c);
`endif
    e.row = 2'(r);
    e.col = 2'(c);
    q.push_back(e);
  endtask

  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) push_model(r, c);
  endtask

  task automatic send_pix(input logic p, input logic s);
    int t;
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    bus.in_sof   = s;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 300) begin
        $display("FAIL in_ready_timeout got=0 required=1");
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send_pix(px(r, c), (r == 0 && c == 0));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(q.size() == 0 && !bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", int'(t >= 300), 0);
    repeat (3) @(negedge clk);
  endtask

  // Backpressure process: holds out_ready low for 5 cycles once triplet (1,1) is presented
  initial begin
    trip_t cap;
    int    t;
    stall_seen = 1'b0;
    wait (stall_arm);
    t = 0;
    while (t < 400) begin
      @(posedge clk);
      #2;
      if (bus.out_valid && bus.out_row == 2'd1 && bus.out_col == 2'd1) break;
      t++;
    end
    if (t < 400) begin
      bus.out_ready = 1'b0;
      cap = '{t: bus.tap_top, m: bus.tap_mid, b: bus.tap_bot, row: bus.out_row, col: bus.out_col};
      repeat (5) begin
        @(posedge clk);
        #2;
        chk("stall_in_ready", int'(bus.in_ready), 0);
        chk("stall_hold", int'({bus.out_valid, bus.tap_top, bus.tap_mid, bus.tap_bot,
                                bus.out_row, bus.out_col}), int'({1'b1, cap}));
      end
      bus.out_ready = 1'b1;
      stall_seen = 1'b1;
    end
  end

  initial begin
    trip_t e;
    int    snap;
    int    t;
    logic [2:0] hand [H];
    n_tests = 0; n_fail = 0; n_out = 0; n_done = 0; exp_done = 0;
    stall_arm = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_pix = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_taps", int'({bus.tap_top, bus.tap_mid, bus.tap_bot}), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_pix(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("no_sof_no_output", n_out, 0);

    // Frame 1: row 1 all ones, hand-computed triplets
    img[0] = 4'b0000; img[1] = 4'b1111; img[2] = 4'b0000;
    hand[0] = 3'b001; hand[1] = 3'b010; hand[2] = 3'b100;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e = '{t: hand[r][2], m: hand[r][1], b: hand[r][0], row: 2'(r), col: 2'(c)};
        q.push_back(e);
      end
    send_frame();
    wait_idle();
    exp_done++;
    chk("f1_out_count", n_out, 12);
    chk("f1_frame_done", n_done, exp_done);
    chk("f1_in_ready_idle", int'(bus.in_ready), 1);

    // Backpressure
    img[0] = 4'b1011; img[1] = 4'b0110; img[2] = 4'b1101;
    push_frame();
    stall_arm = 1'b1;
    send_frame();
    wait_idle();
    exp_done++;
    chk("bp_stall_seen", int'(stall_seen), 1);
    chk("bp_out_count", n_out, 24);
    chk("bp_frame_done", n_done, exp_done);

    // Abort at row 1 col 2
    img[0] = 4'b1100; img[1] = 4'b1011; img[2] = 4'b0000;
    push_model(0, 0);
    push_model(0, 1);
    for (int c = 0; c < W; c++) send_pix(px(0, c), (c == 0));
    send_pix(px(1, 0), 1'b0);
    send_pix(px(1, 1), 1'b0);
    img[0] = 4'b0110; img[1] = 4'b1001; img[2] = 4'b1111;
    push_frame();
    send_frame();
    wait_idle();
    exp_done++;
    chk("abort_out_count", n_out, 38);
    chk("abort_frame_done", n_done, exp_done);

    // Border frame (replicate-aware model)
    img[0] = 4'b1010; img[1] = 4'b0000; img[2] = 4'b0000;
    push_frame();
    send_frame();
    wait_idle();
    exp_done++;
    chk("border_frame_done", n_done, exp_done);

    // Async reset during FLUSH
    img[0] = 4'b1111; img[1] = 4'b0101; img[2] = 4'b0011;
    push_frame();
    send_frame();
    t = 0;
    while (t < 100) begin
      @(posedge clk);
      #2;
      if (bus.out_valid && bus.out_row == 2'd2) break;
      t++;
    end
    chk("flush_reached", int'(t < 100), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("flush_rst_out_valid", int'(bus.out_valid), 0);
    chk("flush_rst_frame_done", int'(bus.frame_done), 0);
    chk("flush_rst_in_ready", int'(bus.in_ready), 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = n_out;
    for (int i = 0; i < 3; i++) send_pix(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("post_rst_no_output", n_out, snap);
    chk("post_rst_no_done", n_done, exp_done);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bin_row_tap_buffer.md
Name: bin_row_tap_buffer

Overview:
- Streaming 3-row line buffer for binarised character images (28x28 by default).
- Sits directly upstream of the three-input OR gate used for vertical dilation.
- Turns a raster pixel stream into aligned vertical triplets (top, mid, bot) that drive the OR inputs i1, i2, i3 one column at a time.
- Adds valid/ready flow control, frame tracking and end-of-frame flush so the OR stage sees exactly one triplet per image pixel.

Parameters:
- IMG_WIDTH, 28, pixels per row (>=2)
- IMG_HEIGHT, 28, rows per frame (>=2)
- COL_W, 5, column counter width (2^COL_W >= IMG_WIDTH)
- ROW_W, 5, row counter width (2^ROW_W >= IMG_HEIGHT)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  pixel present on in_pix
- in_ready  output  1  block accepts pixel this cycle
- in_pix  input  1  binary pixel, raster order
- in_sof  input  1  qualifies in_pix as row 0, col 0 of a new frame
- out_valid  output  1  triplet present
- out_ready  input  1  downstream OR stage consumes triplet
- tap_top  output  1  pixel (row r-1, col c), to OR i1
- tap_mid  output  1  pixel (row r, col c), to OR i2
- tap_bot  output  1  pixel (row r+1, col c), to OR i3
- out_col  output  COL_W  c of current triplet
- out_row  output  ROW_W  r of current triplet
- frame_done  output  1  1-cycle pulse when triplet (IMG_HEIGHT-1, IMG_WIDTH-1) is consumed

Behaviour:
- Reset (async, rst_n=0): state IDLE; counters 0; row memories cleared. All outputs 0 except in_ready=1.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Single output register slot.
  - out_valid and all tap/coord outputs stay stable until transferred.
- Storage: two IMG_WIDTH-bit row memories.
  - prev_row holds row r-1.
  - cur_row holds row r.
  - Indexed by input column counter.
- States:
  - IDLE: in_ready=1. Pixels without in_sof are dropped. Accepted pixel with in_sof goes to FILL with col=1 and the pixel stored in cur_row[0].
  - FILL (row 0 arriving): in_ready=1, no output. Each pixel goes to cur_row[col]. After col IMG_WIDTH-1: col=0, in_row=1, go to STREAM.
  - STREAM (input row k>=1): in_ready = !out_valid | out_ready. Each accepted pixel p at col c loads the output register next cycle:
    - top = prev_row[c] (0 when k=1)
    - mid = cur_row[c]
    - bot = p
    - out_row = k-1, out_col = c
    - Then prev_row[c] <= cur_row[c], cur_row[c] <= p.
  - After the last pixel of row IMG_HEIGHT-1: go to FLUSH.
  - FLUSH: in_ready=0. Emits IMG_WIDTH triplets for row IMG_HEIGHT-1:
    - top = prev_row[c], mid = cur_row[c], bot = 0.
    - One triplet per cycle, subject to the out_ready rule.
    - After the last triplet is transferred: frame_done pulse, then IDLE.
- Latency: triplet valid 1 cycle after the accepted pixel that completes it. Zero-bubble throughput (1 triplet/cycle) when out_ready=1.
- Padding: top of row 0 and bot of row IMG_HEIGHT-1 are 0.
- Simultaneous events:
  - Output transfer and new pixel accept in the same cycle: the register is reloaded, so no bubble.
  - Simultaneous output transfer and load is legal in FLUSH too.
- in_sof while in FILL/STREAM (accepted): abort the frame.
  - Pending triplet discarded (out_valid=0 next cycle).
  - No frame_done.
  - Pixel becomes row 0 col 0, state goes to FILL.
- in_sof during FLUSH: not accepted (in_ready=0).
- Counter wrap: col wraps IMG_WIDTH-1 -> 0. Row counters never exceed IMG_HEIGHT-1.
- Async reset mid-frame: all state lost immediately; the next frame requires in_sof.

Optional Feature:
- Macro BIN_TAP_BORDER_REPLICATE_EN.
- Defined: border rows replicate instead of zero-padding.
  - Row 0: tap_top = tap_mid.
  - Row IMG_HEIGHT-1: tap_bot = tap_mid.
- Undefined: zero padding as in Behaviour. No extra logic.

Test Plan (bench overrides IMG_WIDTH=4, IMG_HEIGHT=3):
- Reset: hold rst_n=0, then release -> out_valid=0, taps=0, frame_done=0, in_ready=1; pixels without in_sof produce no output.
- Row 1 = 1111, rows 0 and 2 = 0000, out_ready=1 -> exactly 12 triplets in raster order:
  - row 0: (t,m,b) = (0,0,1)
  - row 1: (0,1,0)
  - row 2: (1,0,0)
  - frame_done pulses once, with out_row=2, out_col=3.
- Backpressure: out_ready=0 for 5 cycles at row 1 col 1 -> in_ready=0; triplet and coordinates held constant; after release the remaining triplets match an unstalled run and no pixels are lost.
- Abort: in_sof reasserted at row 1 col 2 -> pending triplet dropped; no frame_done; the next 12 triplets match the new frame only.
- Reset mid-FLUSH: rst_n=0 during row 2 output -> out_valid=0 immediately (asynchronously); no frame_done.
- With BIN_TAP_BORDER_REPLICATE_EN, row 0 = 1010, rest 0 -> row 0 taps (1,1,0),(0,0,0),(1,1,0),(0,0,0); row 2 bot = mid.
